// File: rtl/nbcac_rx_packer.sv
// Packs 11-bit NBCAC decoded words LSB-first into 32-bit output words on a
// valid/ready port. Input words that do not fit are dropped and counted.
module nbcac_rx_packer #(
   parameter int DIN_W  = 11,
   parameter int DOUT_W = 32,
   parameter int ACC_W  = 64
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [DIN_W-1:0]  din,
   input  logic              din_valid,
   input  logic              flush,
   output logic [DOUT_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              overflow,
   output logic [15:0]       drop_cnt
);

   // Handshake: dout is transferred on a cycle where dout_valid & dout_ready;
   // dout/dout_valid come from registers only and hold until that transfer.

   localparam int FILL_W = $clog2(ACC_W + 1);
   localparam logic [FILL_W-1:0] DOUT_F  = FILL_W'(DOUT_W);
   localparam logic [FILL_W:0]   DIN_F1  = (FILL_W + 1)'(DIN_W);
   localparam logic [FILL_W:0]   ACC_F1  = (FILL_W + 1)'(ACC_W);

   logic [ACC_W-1:0]  acc, acc_base, acc_next, din_ext;
   logic [FILL_W-1:0] fill, base, fill_next;
   logic [FILL_W:0]   sum;
   logic              pop, accept, drop;

   assign dout       = acc[DOUT_W-1:0];
   assign dout_valid = (fill >= DOUT_F);
   assign pop        = dout_valid & dout_ready;
   assign din_ext    = {{(ACC_W - DIN_W){1'b0}}, din};

   always_comb begin
      base      = pop ? (fill - DOUT_F) : fill;
      acc_base  = pop ? (acc >> DOUT_W) : acc;
      sum       = {1'b0, base} + DIN_F1;
      accept    = din_valid && (sum <= ACC_F1);
      drop      = din_valid && !accept;
      acc_next  = acc_base;
      fill_next = base;
      // Bits at and above base are zero, so OR-ing in the new word is safe.
      if (accept) begin
         acc_next  = acc_base | (din_ext << base);
         fill_next = sum[FILL_W-1:0];
      end else if (!din_valid && flush && (base != '0) && (base < DOUT_F)) begin
         fill_next = DOUT_F;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         acc      <= '0;
         fill     <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         acc  <= acc_next;
         fill <= fill_next;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule
